// File: rtl/im_responder_pkg.sv
// Shared constants, FSM encoding and boot-image contents for the instruction-memory responder.
package im_responder_pkg;

  localparam int unsigned WORD     = 32;
  localparam int unsigned IM_IDX_W = 12;
  localparam int unsigned IM_DEPTH = 4096;

  localparam logic [WORD-1:0] IM_ADDR_START = 32'h0000_3000;
  localparam logic [WORD-1:0] IM_ADDR_END   = 32'h0000_6FFC;
  localparam logic [WORD-1:0] PC_BOOT       = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } im_state_e;

  // Boot image: two real instructions at the reset vector, then an index-tagged fill pattern.
  function automatic logic [WORD-1:0] im_image_word(input logic [IM_IDX_W-1:0] idx);
    logic [WORD-1:0] w;
    w = {8'hA5, idx, ~idx};
    if (idx == IM_IDX_W'(0)) w = 32'h3C01_0001;
    if (idx == IM_IDX_W'(1)) w = 32'h3421_0002;
    return w;
  endfunction

endpackage

// File: rtl/im_responder_if.sv
// Fetch-stage <-> instruction-memory handshake.
//   IAddr  : fetch byte address (fetch -> memory)
//   IRData : instruction word (memory -> fetch)
//   IReady : IRData valid for the current IAddr (memory -> fetch)
interface im_responder_if
  import im_responder_pkg::*;
;
  logic [WORD-1:0] IAddr;
  logic [WORD-1:0] IRData;
  logic            IReady;

  modport master (output IAddr, input IRData, input IReady);
  modport slave  (input IAddr, output IRData, output IReady);
endinterface

// File: rtl/im_responder_rom.sv
// 4096 x 32 instruction ROM holding the boot image, combinational read by word index.
//   idx   : word index
//   rdata : word at idx
module im_responder_rom
  import im_responder_pkg::*;
(
  input  logic [IM_IDX_W-1:0] idx,
  output logic [WORD-1:0]     rdata
);

  logic [WORD-1:0] mem [IM_DEPTH];

  for (genvar i = 0; i < IM_DEPTH; i++) begin : g_word
    assign mem[i] = im_image_word(IM_IDX_W'(i));
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/im_responder.sv
// Instruction-memory responder: latches the fetch address, models LATENCY cycles of access
// time, and returns the word with a ready flag. Bad addresses get an immediate zero word.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   im    : slave side of the fetch handshake (IAddr in, IRData/IReady out)
module im_responder
  import im_responder_pkg::*;
#(
  parameter int unsigned     LATENCY    = 3,
  parameter logic [WORD-1:0] ADDR_START = IM_ADDR_START,
  parameter logic [WORD-1:0] ADDR_END   = IM_ADDR_END
) (
  input logic           clk,
  input logic           reset,
  im_responder_if.slave im
);

  localparam int unsigned CNT_W = 4;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("im_responder: LATENCY must be in 1..15");
  end

  // In range and word aligned.
  function automatic logic addr_good(input logic [WORD-1:0] a);
    return (a >= ADDR_START) && (a <= ADDR_END) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IM_IDX_W-1:0] word_idx(input logic [WORD-1:0] a);
    return IM_IDX_W'((a - ADDR_START) >> 2);
  endfunction

  im_state_e            state;
  logic [WORD-1:0]      req_addr;
  logic                 req_valid;
  logic [CNT_W-1:0]     cnt;
  logic [WORD-1:0]      rdata;

  logic                 miss_c;
  logic [IM_IDX_W-1:0]  rom_idx_c;
  logic [WORD-1:0]      rom_data_c;

  assign miss_c = !req_valid || (im.IAddr != req_addr);

  // ROM is addressed by the incoming address on a miss, else by the latched one; bad addresses park at 0.
  always_comb begin
    rom_idx_c = '0;
    if (miss_c) begin
      if (addr_good(im.IAddr)) rom_idx_c = word_idx(im.IAddr);
    end else if (addr_good(req_addr)) begin
      rom_idx_c = word_idx(req_addr);
    end
  end

  im_responder_rom u_rom (
    .idx   (rom_idx_c),
    .rdata (rom_data_c)
  );

  // Request tracking FSM; any address change restarts the access from scratch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_addr  <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else if (miss_c) begin
      req_addr  <= im.IAddr;
      req_valid <= 1'b1;
      if (!addr_good(im.IAddr)) begin
        rdata <= '0;
        cnt   <= '0;
        state <= ST_READY;
      end else if (LATENCY == 1) begin
        rdata <= rom_data_c;
        cnt   <= '0;
        state <= ST_READY;
      end else begin
        cnt   <= CNT_W'(LATENCY - 1);
        state <= ST_WAIT;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rdata <= rom_data_c;
            state <= ST_READY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign im.IRData = rdata;
  // Combinational so ready drops in the very cycle the fetch address moves.
  assign im.IReady = (state == ST_READY) && (im.IAddr == req_addr);

endmodule

// File: tb/tb_im_responder.sv
module tb_im_responder;

  logic clk;
  logic reset;

  im_responder_if bus0 ();
  im_responder_if bus1 ();

  im_responder #(.LATENCY(3)) u_dut0 (.clk(clk), .reset(reset), .im(bus0));
  im_responder #(.LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .im(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] MEM2 = 32'hA500_2FFD;

  logic [31:0] a [2];

  // Reference model: how many consecutive edges has the current address been held?
  int          lat    [2] = '{3, 1};
  logic [31:0] mlast  [2];
  bit          mvalid [2];
  int          mage   [2];

  function automatic logic [31:0] img(input int i);
    if (i == 0) return 32'h3C01_0001;
    if (i == 1) return 32'h3421_0002;
    return {8'hA5, 12'(i), ~12'(i)};
  endfunction

  function automatic bit good(input logic [31:0] x);
    return (x >= 32'h3000) && (x <= 32'h6FFC) && (x % 4 == 0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] x);
    if (!good(x)) return 32'h0;
    return img(int'((x - 32'h3000) / 4));
  endfunction

  function automatic logic dut_rdy(input int k);
    return (k == 0) ? bus0.IReady : bus1.IReady;
  endfunction

  function automatic logic [31:0] dut_data(input int k);
    return (k == 0) ? bus0.IRData : bus1.IRData;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mvalid[k] = 1'b0;
      mage[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mvalid[k] = 1'b0;
        mage[k]   = 0;
      end else if (!mvalid[k] || a[k] != mlast[k]) begin
        mlast[k]  = a[k];
        mvalid[k] = 1'b1;
        mage[k]   = 1;
      end else if (mage[k] < 1000) begin
        mage[k]++;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      bit exp_rdy;
      int need;
      need    = good(a[k]) ? lat[k] : 1;
      exp_rdy = mvalid[k] && (a[k] == mlast[k]) && (mage[k] >= need);
      chk($sformatf("model_ready%0d", k), 32'(dut_rdy(k)), 32'(exp_rdy));
      if (!reset)
        chk($sformatf("reset_data%0d", k), dut_data(k), 32'h0);
      else if (exp_rdy)
        chk($sformatf("model_data%0d", k), dut_data(k), exp_word(a[k]));
    end
  endtask

  task automatic drive();
    bus0.IAddr = a[0];
    bus1.IAddr = a[1];
  endtask

  // One clock: drive, sample mid-cycle, advance model with the DUT edge. Entered at posedge+1.
  task automatic step(input int k, input bit do_tbl, input bit exp_rdy,
                      input logic [31:0] exp_data, input string name);
    drive();
    #4;
    if (do_tbl) begin
      chk({name, "_ready"}, 32'(dut_rdy(k)), 32'(exp_rdy));
      if (exp_rdy) begin
        chk({name, "_data"}, dut_data(k), exp_data);
      end else if (k == 0) begin
        n_checks++;
        if (dut_data(0) === MEM2) begin
          n_fail++;
          $display("FAIL %s_stale: got %08h required anything but %08h", name, dut_data(0), MEM2);
        end
      end
    end
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    int          rep;
    bit          rdy;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [31:0] rand_addr(input int k);
    int sel;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0: return 32'h3000;
      1: return 32'h6FFC;
      2: return 32'h7000;
      3: return 32'h2FFC;
      4: return 32'h3000 + ($urandom_range(0, 4095) << 2);
      5: return 32'h3000 + ($urandom_range(0, 4095) << 2) + $urandom_range(1, 3);
      6: return $urandom;
      default: return a[k];
    endcase
  endfunction

  initial begin
    tbl.push_back('{0, 32'h3000,  3, 1'b0, 32'h0,         "boot_wait"});
    tbl.push_back('{0, 32'h3000, 11, 1'b1, 32'h3C01_0001, "boot_hold"});
    tbl.push_back('{0, 32'h3004,  3, 1'b0, 32'h0,         "next_wait"});
    tbl.push_back('{0, 32'h3004,  2, 1'b1, 32'h3421_0002, "next_rdy"});
    tbl.push_back('{0, 32'h3008,  1, 1'b0, 32'h0,         "abort_first"});
    tbl.push_back('{0, 32'h4180,  3, 1'b0, 32'h0,         "abort_wait"});
    tbl.push_back('{0, 32'h4180,  2, 1'b1, 32'hA546_0B9F, "abort_rdy"});
    tbl.push_back('{0, 32'h2FFC,  1, 1'b0, 32'h0,         "below_wait"});
    tbl.push_back('{0, 32'h2FFC,  2, 1'b1, 32'h0,         "below_rdy"});
    tbl.push_back('{0, 32'h3002,  1, 1'b0, 32'h0,         "misalign_wait"});
    tbl.push_back('{0, 32'h3002,  1, 1'b1, 32'h0,         "misalign_rdy"});
    tbl.push_back('{0, 32'h7000,  1, 1'b0, 32'h0,         "above_wait"});
    tbl.push_back('{0, 32'h7000,  1, 1'b1, 32'h0,         "above_rdy"});
    tbl.push_back('{0, 32'h6FFC,  3, 1'b0, 32'h0,         "last_wait"});
    tbl.push_back('{0, 32'h6FFC,  1, 1'b1, 32'hA5FF_F000, "last_rdy"});
    tbl.push_back('{1, 32'h3000,  1, 1'b0, 32'h0,         "l1_a_wait"});
    tbl.push_back('{1, 32'h3000,  1, 1'b1, 32'h3C01_0001, "l1_a_rdy"});
    tbl.push_back('{1, 32'h3004,  1, 1'b0, 32'h0,         "l1_b_wait"});
    tbl.push_back('{1, 32'h3004,  1, 1'b1, 32'h3421_0002, "l1_b_rdy"});
    tbl.push_back('{1, 32'h3008,  1, 1'b0, 32'h0,         "l1_c_wait"});
    tbl.push_back('{1, 32'h3008,  1, 1'b1, MEM2,          "l1_c_rdy"});

    reset = 1'b0;
    a[0] = 32'h3000;
    a[1] = 32'h7FF0;
    mlast[0] = '0;
    mlast[1] = '0;
    model_clear();
    drive();
    @(posedge clk);
    #1;
    step(0, 1'b0, 1'b0, 32'h0, "rst");
    step(0, 1'b0, 1'b0, 32'h0, "rst");
    reset = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        a[tbl[i].inst] = tbl[i].addr;
        step(tbl[i].inst, 1'b1, tbl[i].rdy, tbl[i].data, tbl[i].name);
      end
    end

    // Reset in the second WAIT cycle clears outputs without an edge, then a full-latency restart.
    a[0] = 32'h3004;
    step(0, 1'b1, 1'b0, 32'h0, "mw_p0");
    step(0, 1'b1, 1'b0, 32'h0, "mw_p1");
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    chk("async_rst_ready", 32'(bus0.IReady), 32'h0);
    chk("async_rst_data",  bus0.IRData,      32'h0);
    chk("async_rst_data1", bus1.IRData,      32'h0);
    #2;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
    step(0, 1'b0, 1'b0, 32'h0, "rst_hold");
    reset = 1'b1;
    step(0, 1'b1, 1'b0, 32'h0,         "post_rst_w0");
    step(0, 1'b1, 1'b0, 32'h0,         "post_rst_w1");
    step(0, 1'b1, 1'b0, 32'h0,         "post_rst_w2");
    step(0, 1'b1, 1'b1, 32'h3421_0002, "post_rst_rdy");

    // Address wanders away and back within one WAIT cycle: count continues.
    a[0] = 32'h3010;
    step(0, 1'b1, 1'b0, 32'h0, "ret_p0");
    a[0] = 32'h3014;
    drive();
    #1;
    chk("ret_glitch_ready", 32'(bus0.IReady), 32'h0);
    a[0] = 32'h3010;
    step(0, 1'b1, 1'b0, 32'h0,         "ret_p1");
    step(0, 1'b1, 1'b0, 32'h0,         "ret_p2");
    step(0, 1'b1, 1'b1, 32'hA500_4FFB, "ret_rdy");

    // Address changing every cycle never completes a good fetch on the LATENCY=3 port.
    for (int i = 0; i < 8; i++) begin
      a[0] = 32'h3100 + 32'(i * 4);
      step(0, 1'b1, 1'b0, 32'h0, "b2b");
    end

    for (int i = 0; i < 600; i++) begin
      a[0] = rand_addr(0);
      a[1] = rand_addr(1);
      step(0, 1'b0, 1'b0, 32'h0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
